// File: rtl/mmui_core.sv
// mmui_core: N x N unsigned matrix multiply unit, C = A * B.
//
// The host loads A and B one row per cycle, pulses start, waits for done and
// then reads C one row per cycle. Each output row i is produced by streaming
// A row i and B rows 0..N-1 through N multiply-accumulate lanes. Lane j
// accumulates A[i][k] * B[k][j]. The lane totals are then written back as
// C row i.
//
// Ports:
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   start             : begin a multiply; only sampled in IDLE
//   busy              : high while the multiply is running
//   done              : one-cycle pulse when C is complete
//   A_USR_wr/addr/din : host write of one A row (ignored while busy or addr >= N)
//   B_USR_wr/addr/din : host write of one B row (same rules)
//   C_USR_rd/addr     : host read of one C row, 1-cycle latency
//   C_USR_dout        : C row data, holds between reads, 0 for addr >= N
//   dbg_state_o       : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Row element j of a row bus lives at [j*WIDTH +: WIDTH] for A and B, and at
// [j*M_WIDTH +: M_WIDTH] for C.

module mmui_core #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2 * WIDTH + N - 1,
  parameter int ADDR    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 A_USR_wr,
  input  logic [ADDR-1:0]      A_USR_addr,
  input  logic [N*WIDTH-1:0]   A_USR_din,
  input  logic                 B_USR_wr,
  input  logic [ADDR-1:0]      B_USR_addr,
  input  logic [N*WIDTH-1:0]   B_USR_din,
  input  logic                 C_USR_rd,
  input  logic [ADDR-1:0]      C_USR_addr,
  output logic [N*M_WIDTH-1:0] C_USR_dout,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Per-row step counter: steps 0..N-1 issue reads, step N is the read
  // latency cycle, step N+1 writes the row back.
  localparam int S_W = $clog2(N + 2);
  localparam logic [S_W-1:0]  NUM_RD    = S_W'(N);
  localparam logic [S_W-1:0]  LAST_STEP = S_W'(N + 1);
  localparam logic [ADDR-1:0] LAST_ROW  = ADDR'(N - 1);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [ADDR-1:0]    row_q;
  logic [S_W-1:0]     step_q;

  // MAC pipeline control, aligned with the memory read data.
  logic               mac_vld_q;
  logic               mac_clr_q;
  logic [ADDR-1:0]    mac_k_q;

  logic [N*WIDTH-1:0]   a_mem [N];
  logic [N*WIDTH-1:0]   b_mem [N];
  logic [N*M_WIDTH-1:0] c_mem [N];

  logic [N*WIDTH-1:0]   a_rd_q;
  logic [N*WIDTH-1:0]   b_rd_q;
  logic [N*M_WIDTH-1:0] c_dout_q;

  logic [M_WIDTH-1:0]   acc_q [N];
  logic [M_WIDTH-1:0]   acc_d [N];
  logic [2*WIDTH-1:0]   prod  [N];
  logic [WIDTH-1:0]     a_sc;
  logic [N*M_WIDTH-1:0] c_wdata;
  logic                 c_we;

  assign busy        = busy_q;
  assign done        = done_q;
  assign C_USR_dout  = c_dout_q;
  assign dbg_state_o = state_q;

  assign c_we = (state_q == S_RUN) && (step_q == LAST_STEP);

  // Sequencer FSM with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_q     <= '0;
      step_q    <= '0;
      mac_vld_q <= 1'b0;
      mac_clr_q <= 1'b0;
      mac_k_q   <= '0;
    end else begin
      mac_vld_q <= (state_q == S_RUN) && (step_q < NUM_RD);
      mac_clr_q <= (step_q == '0);
      mac_k_q   <= step_q[ADDR-1:0];
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            row_q   <= '0;
            step_q  <= '0;
          end
        end
        S_RUN: begin
          if (step_q == LAST_STEP) begin
            step_q <= '0;
            if (row_q == LAST_ROW) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Row memories and their registered read ports. Not reset: contents
  // survive reset by design.
  always_ff @(posedge clk) begin
    if (A_USR_wr && !busy_q && (int'(A_USR_addr) < N)) begin
      a_mem[A_USR_addr] <= A_USR_din;
    end
    if (B_USR_wr && !busy_q && (int'(B_USR_addr) < N)) begin
      b_mem[B_USR_addr] <= B_USR_din;
    end
    if (c_we) begin
      c_mem[row_q] <= c_wdata;
    end
    a_rd_q <= a_mem[row_q];
    if (step_q < NUM_RD) begin
      b_rd_q <= b_mem[step_q[ADDR-1:0]];
    end
  end

  // Host C read port; nonblocking update gives old data on a same-row write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_dout_q <= '0;
    end else if (C_USR_rd) begin
      c_dout_q <= (int'(C_USR_addr) < N) ? c_mem[C_USR_addr] : '0;
    end
  end

  // A row i is read once per k; the scalar A[i][k] is picked from it.
  assign a_sc = a_rd_q[int'(mac_k_q)*WIDTH +: WIDTH];

  always_comb begin
    c_wdata = '0;
    for (int j = 0; j < N; j++) begin
      prod[j]  = {{WIDTH{1'b0}}, a_sc} * {{WIDTH{1'b0}}, b_rd_q[j*WIDTH +: WIDTH]};
      acc_d[j] = (mac_clr_q ? '0 : acc_q[j]) + M_WIDTH'(prod[j]);
      c_wdata[j*M_WIDTH +: M_WIDTH] = acc_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) acc_q[j] <= '0;
    end else if (mac_vld_q) begin
      for (int j = 0; j < N; j++) acc_q[j] <= acc_d[j];
    end
  end

endmodule

// File: tb/tb_mmui_core.sv
module tb_mmui_core;
  localparam int N       = 6;
  localparam int WIDTH   = 16;
  localparam int M_WIDTH = 2 * WIDTH + N - 1;
  localparam int ADDR    = 3;
  localparam int LAT     = N * (N + 2);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 busy, done;
  logic                 A_USR_wr = 1'b0;
  logic [ADDR-1:0]      A_USR_addr = '0;
  logic [N*WIDTH-1:0]   A_USR_din = '0;
  logic                 B_USR_wr = 1'b0;
  logic [ADDR-1:0]      B_USR_addr = '0;
  logic [N*WIDTH-1:0]   B_USR_din = '0;
  logic                 C_USR_rd = 1'b0;
  logic [ADDR-1:0]      C_USR_addr = '0;
  logic [N*M_WIDTH-1:0] C_USR_dout;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;

  mmui_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .A_USR_wr(A_USR_wr), .A_USR_addr(A_USR_addr), .A_USR_din(A_USR_din),
    .B_USR_wr(B_USR_wr), .B_USR_addr(B_USR_addr), .B_USR_din(B_USR_din),
    .C_USR_rd(C_USR_rd), .C_USR_addr(C_USR_addr), .C_USR_dout(C_USR_dout),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: all called right after a falling edge; inputs are
  // sampled on the next rising edge, outputs observed at the falling edge.
  task automatic write_ab(input int addr, input logic [N*WIDTH-1:0] a,
                          input logic [N*WIDTH-1:0] b);
    A_USR_wr = 1'b1; A_USR_addr = ADDR'(addr); A_USR_din = a;
    B_USR_wr = 1'b1; B_USR_addr = ADDR'(addr); B_USR_din = b;
    @(negedge clk);
    A_USR_wr = 1'b0; B_USR_wr = 1'b0;
  endtask

  task automatic read_c(input int addr, output logic [N*M_WIDTH-1:0] d);
    C_USR_rd = 1'b1; C_USR_addr = ADDR'(addr);
    @(negedge clk);
    C_USR_rd = 1'b0;
    d = C_USR_dout;
  endtask

  // Pulse start (held start_cycles), optionally re-pulse at cycle mid_start.
  // lat is the cycle count from the busy-rise edge to done (0 = never).
  task automatic run_mult(input int start_cycles, input int mid_start,
                          output int lat, output int n_done,
                          output logic busy0, output logic busy_at_done);
    start = 1'b1;
    @(negedge clk);
    busy0 = busy; lat = 0; n_done = 0; busy_at_done = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      start = (c < start_cycles) || (c == mid_start);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (lat == 0) begin lat = c; busy_at_done = busy; end
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [N*WIDTH-1:0] seq_row();
    logic [N*WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*WIDTH +: WIDTH] = WIDTH'(j + 1);
    return r;
  endfunction

  function automatic logic [N*WIDTH-1:0] fill_row(input int v);
    logic [N*WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*WIDTH +: WIDTH] = WIDTH'(v);
    return r;
  endfunction

  function automatic logic [N*M_WIDTH-1:0] uniform_c();
    logic [N*M_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*M_WIDTH +: M_WIDTH] = M_WIDTH'(21 * (j + 1));
    return r;
  endfunction

  function automatic logic [N*M_WIDTH-1:0] fill_c(input logic [M_WIDTH-1:0] v);
    logic [N*M_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*M_WIDTH +: M_WIDTH] = v;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start      = 1'($urandom_range(0, 1));
      A_USR_wr   = 1'($urandom_range(0, 1));
      A_USR_addr = ADDR'($urandom_range(0, 7));
      A_USR_din  = {$urandom, $urandom, $urandom};
      B_USR_wr   = 1'($urandom_range(0, 1));
      B_USR_addr = ADDR'($urandom_range(0, 7));
      B_USR_din  = {$urandom, $urandom, $urandom};
      C_USR_rd   = 1'($urandom_range(0, 1));
      C_USR_addr = ADDR'($urandom_range(0, 7));
      @(negedge clk);
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (C_USR_dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", C_USR_dout); end
    end
    start = 1'b0; A_USR_wr = 1'b0; B_USR_wr = 1'b0; C_USR_rd = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_uniform();
    int lat, nd; logic b0, bd;
    logic [N*M_WIDTH-1:0] d;
    for (int i = 0; i < N; i++) write_ab(i, seq_row(), seq_row());
    run_mult(3, 0, lat, nd, b0, bd);
    checks += 4;
    if (b0 !== 1'b1) begin errors++; $display("FAIL uniform_busy_rise: got %b expected 1", b0); end
    if (lat != LAT) begin errors++; $display("FAIL uniform_latency: got %0d expected %0d", lat, LAT); end
    if (nd != 1) begin errors++; $display("FAIL uniform_done_count: got %0d expected 1", nd); end
    if (bd !== 1'b0) begin errors++; $display("FAIL uniform_busy_at_done: got %b expected 0", bd); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      checks++;
      if (d !== uniform_c()) begin errors++; $display("FAIL uniform_row%0d: got %h expected %h", i, d, uniform_c()); end
    end
  endtask

  task automatic test_identity();
    int lat, nd; logic b0, bd;
    logic [N*WIDTH-1:0] a, b;
    logic [N*M_WIDTH-1:0] d, e;
    for (int i = 0; i < N; i++) begin
      a = '0; a[i*WIDTH +: WIDTH] = 16'd1;
      for (int j = 0; j < N; j++) b[j*WIDTH +: WIDTH] = WIDTH'(16 * i + j);
      write_ab(i, a, b);
    end
    run_mult(1, 0, lat, nd, b0, bd);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL identity_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      for (int j = 0; j < N; j++) e[j*M_WIDTH +: M_WIDTH] = M_WIDTH'(16 * i + j);
      checks++;
      if (d !== e) begin errors++; $display("FAIL identity_row%0d: got %h expected %h", i, d, e); end
    end
  endtask

  // Runs with A = I and B[i][j] = 16i+j already loaded.
  task automatic test_addressing();
    int lat, nd; logic b0, bd;
    logic [N*M_WIDTH-1:0] d, e;
    write_ab(6, fill_row(16'hFFFF), fill_row(16'hFFFF));
    write_ab(7, fill_row(16'hFFFF), fill_row(16'hFFFF));
    run_mult(1, 0, lat, nd, b0, bd);
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      for (int j = 0; j < N; j++) e[j*M_WIDTH +: M_WIDTH] = M_WIDTH'(16 * i + j);
      checks++;
      if (d !== e) begin errors++; $display("FAIL addr_oob_write_row%0d: got %h expected %h", i, d, e); end
    end
    read_c(6, d);
    checks++;
    if (d !== '0) begin errors++; $display("FAIL addr_read6: got %h expected 0", d); end
    read_c(1, d);
    read_c(7, d);
    checks++;
    if (d !== '0) begin errors++; $display("FAIL addr_read7: got %h expected 0", d); end
    // Latency and hold: nothing before the edge, new row after, held after.
    for (int j = 0; j < N; j++) e[j*M_WIDTH +: M_WIDTH] = M_WIDTH'(48 + j);
    C_USR_rd = 1'b1; C_USR_addr = 3'd3;
    #2;
    checks++;
    if (C_USR_dout !== '0) begin errors++; $display("FAIL read_before_edge: got %h expected 0", C_USR_dout); end
    @(negedge clk);
    C_USR_rd = 1'b0; C_USR_addr = 3'd1;
    checks++;
    if (C_USR_dout !== e) begin errors++; $display("FAIL read_latency: got %h expected %h", C_USR_dout, e); end
    @(negedge clk);
    checks++;
    if (C_USR_dout !== e) begin errors++; $display("FAIL read_hold: got %h expected %h", C_USR_dout, e); end
  endtask

  task automatic test_start_mid_run();
    int lat, nd; logic b0, bd;
    logic [N*M_WIDTH-1:0] d;
    for (int i = 0; i < N; i++) write_ab(i, seq_row(), seq_row());
    run_mult(1, 20, lat, nd, b0, bd);
    checks += 2;
    if (nd != 1) begin errors++; $display("FAIL midstart_done_count: got %0d expected 1", nd); end
    if (lat != LAT) begin errors++; $display("FAIL midstart_latency: got %0d expected %0d", lat, LAT); end
    read_c(4, d);
    checks++;
    if (d !== uniform_c()) begin errors++; $display("FAIL midstart_row4: got %h expected %h", d, uniform_c()); end
  endtask

  // A and B hold the uniform pattern; writes during RUN must not land.
  task automatic test_write_during_run();
    int nd;
    logic [N*M_WIDTH-1:0] d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; nd = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c < 45) begin
        A_USR_wr = 1'b1; A_USR_addr = ADDR'(c % 8); A_USR_din = fill_row(16'hFFFF);
        B_USR_wr = 1'b1; B_USR_addr = ADDR'((c + 3) % 8); B_USR_din = fill_row(16'hFFFF);
      end else begin
        A_USR_wr = 1'b0; B_USR_wr = 1'b0;
      end
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL wr_run_done_count: got %0d expected 1", nd); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      checks++;
      if (d !== uniform_c()) begin errors++; $display("FAIL wr_run_row%0d: got %h expected %h", i, d, uniform_c()); end
    end
  endtask

  // C holds the uniform result; A = B = all ones gives 6 everywhere.
  task automatic test_reset_mid_run();
    int lat, nd; logic b0, bd;
    logic [N*M_WIDTH-1:0] d, e;
    for (int i = 0; i < N; i++) write_ab(i, fill_row(1), fill_row(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    if (C_USR_dout !== '0) begin errors++; $display("FAIL midreset_dout: got %h expected 0", C_USR_dout); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", nd); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      e = (i < 2) ? fill_c(M_WIDTH'(6)) : uniform_c();
      checks++;
      if (d !== e) begin errors++; $display("FAIL midreset_keep_row%0d: got %h expected %h", i, d, e); end
    end
    run_mult(1, 0, lat, nd, b0, bd);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL rerun_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      checks++;
      if (d !== fill_c(M_WIDTH'(6))) begin errors++; $display("FAIL rerun_row%0d: got %h expected %h", i, d, fill_c(M_WIDTH'(6))); end
    end
  endtask

  task automatic test_max();
    int lat, nd; logic b0, bd;
    logic [N*M_WIDTH-1:0] d, e;
    e = fill_c(37'h5_FFF4_0006);
    for (int i = 0; i < N; i++) write_ab(i, fill_row(16'hFFFF), fill_row(16'hFFFF));
    run_mult(1, 0, lat, nd, b0, bd);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < N; i++) begin
      read_c(i, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL max_row%0d: got %h expected %h", i, d, e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_uniform();
    test_identity();
    test_addressing();
    test_start_mid_run();
    test_write_during_run();
    test_reset_mid_run();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
